// File: rtl/board_pkg.sv
// Shared types and helpers for the minesweeper board generator:
// FSM states, LFSR constants and tile index arithmetic.
package board_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PLACE = 2'd1,
      COUNT = 2'd2,
      DONE  = 2'd3
   } state_e;

   localparam int LFSR_W = 16;
   localparam int TAP_A  = 15;
   localparam int TAP_B  = 13;
   localparam int TAP_C  = 12;
   localparam int TAP_D  = 10;

   localparam logic [LFSR_W-1:0] LFSR_DEFAULT_SEED = 16'hACE1;

   function automatic int idx_width(input int total);
      return (total <= 2) ? 1 : $clog2(total);
   endfunction

   function automatic int row_of(input int idx, input int grid);
      return idx / grid;
   endfunction

   function automatic int col_of(input int idx, input int grid);
      return idx % grid;
   endfunction

   // Fibonacci step: shift left, feedback enters at bit 0.
   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] l);
      return {l[LFSR_W-2:0], l[TAP_A] ^ l[TAP_B] ^ l[TAP_C] ^ l[TAP_D]};
   endfunction

endpackage

// File: rtl/adj_counter.sv
// Combinational neighbour-mine counter for one tile; edges are masked,
// the grid does not wrap.
module adj_counter
   import board_pkg::*;
#(
   parameter  int GRID_SIZE   = 8,
   localparam int TOTAL_TILES = GRID_SIZE * GRID_SIZE,
   localparam int IDX_W       = idx_width(TOTAL_TILES)
) (
   input  logic [TOTAL_TILES-1:0] mine_map_i,
   input  logic [IDX_W-1:0]       index_i,
   output logic [3:0]             count_o
);

   always_comb begin
      logic [3:0] cnt;
      int         row;
      int         col;
      int         nr;
      int         nc;
      cnt = '0;
      row = row_of(int'(index_i), GRID_SIZE);
      col = col_of(int'(index_i), GRID_SIZE);
      nr  = 0;
      nc  = 0;
      for (int dr = -1; dr <= 1; dr++) begin
         for (int dc = -1; dc <= 1; dc++) begin
            nr = row + dr;
            nc = col + dc;
            if ((dr != 0 || dc != 0) && nr >= 0 && nr < GRID_SIZE &&
                nc >= 0 && nc < GRID_SIZE) begin
               if (mine_map_i[IDX_W'(nr * GRID_SIZE + nc)]) begin
                  cnt = cnt + 4'd1;
               end
            end
         end
      end
      count_o = cnt;
   end

endmodule

// File: rtl/board_gen.sv
// Board writer: places NUM_MINES mines with an LFSR (never on the safe tile),
// then sweeps every tile once to fill in neighbour counts.
module board_gen
   import board_pkg::*;
#(
   parameter  int                GRID_SIZE    = 8,
   parameter  int                NUM_MINES    = 10,
   parameter  logic [LFSR_W-1:0] DEFAULT_SEED = LFSR_DEFAULT_SEED,
   localparam int                TOTAL_TILES  = GRID_SIZE * GRID_SIZE,
   localparam int                IDX_W        = idx_width(TOTAL_TILES)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [LFSR_W-1:0]        seed,
   input  logic [IDX_W-1:0]         safe_index,
   output logic                     busy,
   output logic                     done,
   output logic                     board_valid,
   output logic [TOTAL_TILES-1:0]   mine_map,
   output logic [TOTAL_TILES*4-1:0] adj
);

   state_e                   state_q,  state_d;
   logic [LFSR_W-1:0]        lfsr_q,   lfsr_d;
   logic [IDX_W-1:0]         safe_q,   safe_d;
   logic [IDX_W-1:0]         placed_q, placed_d;
   logic [IDX_W-1:0]         cidx_q,   cidx_d;
   logic [TOTAL_TILES-1:0]   mine_q,   mine_d;
   logic [TOTAL_TILES*4-1:0] adj_q,    adj_d;
   logic                     busy_q,   busy_d;
   logic                     done_q,   done_d;
   logic                     valid_q,  valid_d;

   logic [IDX_W-1:0] cand;
   logic [3:0]       adj_cnt;

   assign cand = lfsr_q[IDX_W-1:0];

   // Single shared counter, walked across the board during COUNT.
   adj_counter #(.GRID_SIZE(GRID_SIZE)) u_adj_counter (
      .mine_map_i (mine_q),
      .index_i    (cidx_q),
      .count_o    (adj_cnt)
   );

   always_comb begin
      state_d  = state_q;
      lfsr_d   = lfsr_q;
      safe_d   = safe_q;
      placed_d = placed_q;
      cidx_d   = cidx_q;
      mine_d   = mine_q;
      adj_d    = adj_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      valid_d  = valid_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               lfsr_d   = (seed == '0) ? DEFAULT_SEED : seed;
               safe_d   = safe_index;
               mine_d   = '0;
               adj_d    = '0;
               placed_d = '0;
               cidx_d   = '0;
               valid_d  = 1'b0;
               busy_d   = 1'b1;
               state_d  = PLACE;
            end
         end
         PLACE: begin
            lfsr_d = lfsr_next(lfsr_q);
            if (int'(cand) < TOTAL_TILES && cand != safe_q && !mine_q[cand]) begin
               mine_d[cand] = 1'b1;
               placed_d     = placed_q + IDX_W'(1);
               if (placed_q == IDX_W'(NUM_MINES - 1)) begin
                  cidx_d  = '0;
                  state_d = COUNT;
               end
            end
         end
         COUNT: begin
            adj_d[{cidx_q, 2'b00} +: 4] = adj_cnt;
            if (cidx_q == IDX_W'(TOTAL_TILES - 1)) begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               valid_d = 1'b1;
               state_d = DONE;
            end else begin
               cidx_d = cidx_q + IDX_W'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= IDLE;
         lfsr_q   <= DEFAULT_SEED;
         safe_q   <= '0;
         placed_q <= '0;
         cidx_q   <= '0;
         mine_q   <= '0;
         adj_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         lfsr_q   <= lfsr_d;
         safe_q   <= safe_d;
         placed_q <= placed_d;
         cidx_q   <= cidx_d;
         mine_q   <= mine_d;
         adj_q    <= adj_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         valid_q  <= valid_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign board_valid = valid_q;
   assign mine_map    = mine_q;
   assign adj         = adj_q;

endmodule

// File: tb/tb_board_gen.sv
// Bench for board_gen: an 8x8/10-mine instance driven with random seeds and
// checked by a scoreboard, plus a 2x2/3-mine instance with a fixed board.
module tb_board_gen;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic [15:0]   seed = '0;
   logic [5:0]    safe_index = '0;
   logic          busy, done, board_valid;
   logic [63:0]   mine_map;
   logic [255:0]  adj;

   logic          start2 = 1'b0;
   logic [15:0]   seed2 = '0;
   logic [1:0]    safe2 = '0;
   logic          busy2, done2, valid2;
   logic [3:0]    mine2;
   logic [15:0]   adj2;

   int errors = 0;
   int checks = 0;

   logic [63:0]  exp_mine_q[$];
   logic [255:0] exp_adj_q[$];
   int           exp_len_q[$];
   int           busy_cnt = 0;

   board_gen dut (
      .clk(clk), .rst(rst), .start(start), .seed(seed), .safe_index(safe_index),
      .busy(busy), .done(done), .board_valid(board_valid),
      .mine_map(mine_map), .adj(adj)
   );

   board_gen #(.GRID_SIZE(2), .NUM_MINES(3)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .seed(seed2), .safe_index(safe2),
      .busy(busy2), .done(done2), .board_valid(valid2),
      .mine_map(mine2), .adj(adj2)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference board built from the rules: random walk of candidates, then a
   // zero-padded 3x3 window sum minus the centre.
   task automatic gen_model(input int g, input int nm, input logic [15:0] seed_in,
                            input int safe, output logic [63:0] mm,
                            output logic [255:0] aa, output int place_cycles);
      logic [15:0] l;
      int total, mask, cand, placed, n;
      int pad[0:17][0:17];
      total = g * g;
      mask = (1 << $clog2(total)) - 1;
      l = (seed_in == 16'd0) ? 16'hACE1 : seed_in;
      mm = '0;
      aa = '0;
      placed = 0;
      place_cycles = 0;
      while (placed < nm && place_cycles < 100000) begin
         place_cycles++;
         cand = int'(l) & mask;
         if (cand < total && cand != safe && !mm[6'(cand)]) begin
            mm[6'(cand)] = 1'b1;
            placed++;
         end
         l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
      end
      for (int r = 0; r < 18; r++)
         for (int c = 0; c < 18; c++)
            pad[r][c] = 0;
      for (int t = 0; t < total; t++)
         pad[t / g + 1][t % g + 1] = mm[6'(t)] ? 1 : 0;
      for (int t = 0; t < total; t++) begin
         n = 0;
         for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
               n += pad[t / g + r][t % g + c];
         n -= pad[t / g + 1][t % g + 1];
         aa[8'(t * 4) +: 4] = 4'(n);
      end
   endtask

   task automatic do_start(input logic [15:0] s, input int sf);
      @(negedge clk);
      start = 1'b1;
      seed = s;
      safe_index = 6'(sf);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n;
      n = 0;
      while (done !== 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL wait_done: got no done after %0d cycles, required a done pulse", n);
      end
   endtask

   task automatic push_expected(input logic [15:0] s, input int sf);
      logic [63:0]  mm;
      logic [255:0] aa;
      int           pc;
      gen_model(8, 10, s, sf, mm, aa, pc);
      exp_mine_q.push_back(mm);
      exp_adj_q.push_back(aa);
      exp_len_q.push_back(pc + 64);
   endtask

   // Monitor: every done pulse of the main instance is matched with the oldest
   // expected board; busy length covers PLACE plus the 64-cycle sweep.
   always @(negedge clk) begin
      if (!rst) begin
         busy_cnt = 0;
      end else if (done) begin
         if (exp_mine_q.size() == 0) begin
            check("unexpected_done", 256'(1), 256'(0));
         end else begin
            check("mine_map", 256'(mine_map), 256'(exp_mine_q.pop_front()));
            check("adj", adj, exp_adj_q.pop_front());
            check("busy_len", 256'(busy_cnt), 256'(exp_len_q.pop_front()));
         end
         busy_cnt = 0;
      end else if (busy) begin
         busy_cnt++;
      end
   end

   initial begin
      logic [15:0]  s;
      int           sf;
      int           dcount;
      logic [63:0]  mm;
      logic [255:0] aa;
      int           pc;

      // Reset held with start asserted.
      rst = 1'b0;
      start = 1'b1;
      start2 = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_busy", 256'(busy), 256'(0));
      check("rst_done", 256'(done), 256'(0));
      check("rst_valid", 256'(board_valid), 256'(0));
      check("rst_mine", 256'(mine_map), 256'(0));
      check("rst_adj", adj, 256'(0));
      check("rst2_all", 256'({busy2, done2, valid2, mine2, adj2}), 256'(0));
      start = 1'b0;
      start2 = 1'b0;
      rst = 1'b1;

      // Fixed 2x2 board.
      @(negedge clk);
      start2 = 1'b1;
      seed2 = 16'h1234;
      safe2 = 2'd0;
      @(negedge clk);
      start2 = 1'b0;
      dcount = 0;
      for (int k = 0; k < 120; k++) begin
         @(negedge clk);
         if (done2) dcount++;
      end
      check("g2_done_pulses", 256'(dcount), 256'(1));
      check("g2_valid", 256'(valid2), 256'(1));
      check("g2_mine", 256'(mine2), 256'(4'b1110));
      check("g2_adj", 256'(adj2), 256'(16'h2223));

      // Random boards on the 8x8 instance.
      for (int i = 0; i < 100; i++) begin
         s = 16'($urandom_range(0, 65535));
         sf = int'($urandom_range(0, 63));
         push_expected(s, sf);
         do_start(s, sf);
         check("valid_drop", 256'(board_valid), 256'(0));
         check("busy_set", 256'(busy), 256'(1));
         if (i % 10 == 3) begin
            @(negedge clk);
            start = 1'b1;
            seed = ~s;
            safe_index = ~6'(sf);
            @(negedge clk);
            start = 1'b0;
         end
         wait_done(5000);
         check("valid_at_done", 256'(board_valid), 256'(1));
         check("popcount", 256'($countones(mine_map)), 256'(10));
         check("safe_clear", 256'(mine_map[6'(sf)]), 256'(0));
         if (i % 10 == 7) begin
            start = 1'b1;
            seed = 16'h5555;
            @(negedge clk);
            start = 1'b0;
            check("done_start_busy", 256'(busy), 256'(0));
            check("done_start_done", 256'(done), 256'(0));
            check("done_start_valid", 256'(board_valid), 256'(1));
         end
      end

      // Reset with the sweep at tile 20.
      gen_model(8, 10, 16'h0000, 5, mm, aa, pc);
      do_start(16'h0000, 5);
      repeat (pc + 20) @(negedge clk);
      check("pre_abort_busy", 256'(busy), 256'(1));
      rst = 1'b0;
      @(negedge clk);
      check("abort_busy", 256'(busy), 256'(0));
      check("abort_done", 256'(done), 256'(0));
      check("abort_valid", 256'(board_valid), 256'(0));
      check("abort_mine", 256'(mine_map), 256'(0));
      check("abort_adj", adj, 256'(0));
      rst = 1'b1;

      // Zero seed falls back to the default seed.
      push_expected(16'h0000, 5);
      do_start(16'h0000, 5);
      wait_done(5000);
      push_expected(16'hACE1, 5);
      do_start(16'hACE1, 5);
      wait_done(5000);

      repeat (3) @(negedge clk);
      check("scoreboard_drained", 256'(exp_mine_q.size()), 256'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got no completion, required finish before time limit");
      $fatal(1, "timeout");
   end

endmodule
